writeback_regfile: RTL
======================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 wb_valid  input  1  memory-stage result present this cycle; 0 = stall, no state change.
REQ-006 icode  input  4  instruction code of the retiring instruction.
REQ-007 cnd  input  1  condition result from execute (cmovXX qualifier).
REQ-008 rA, rB  input  4 each  register specifiers; 4'hF = none.
REQ-009 valE, valM  input  64 each  ALU result and memory read data.
REQ-010 stat_in  input  2  memory-stage status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
REQ-011 rd_addrA, rd_addrB  input  4 each  read-port addresses for decode.
REQ-012 rd_dataA, rd_dataB  output  64 each  read-port data.
REQ-013 proc_stat  output  2  registered processor status.
REQ-014 halted  output  1  1 when state is not RUN.
REQ-015 retired  output  CNT_W  count of instructions retired with AOK.

Function
REQ-016 Register file: 15 x 64-bit registers, indices 0-14; index 15 never stored.
REQ-017 Reads combinational; address 15 returns 0; same-cycle write not forwarded (old value read until edge).
REQ-018 dstE: icode 2 -> rB if cnd else 15; icode 3, 6 -> rB; icode 8, 9, A, B -> 4 (%rsp); else 15.
REQ-019 dstM: icode 5, B -> rA; else 15.
REQ-020 Write enable = wb_valid & state RUN & stat_in==AOK; valE to dstE and valM to dstM on the same edge.
REQ-021 dstE==dstM (popq %rsp): valM written, valE discarded.
REQ-022 FSM states RUN, HALT, ERR.
REQ-023 RUN -> HALT when wb_valid & stat_in==1; RUN -> ERR when wb_valid & stat_in in {2,3}; else stay RUN.
REQ-024 HALT and ERR terminal until rst; no register writes, counter frozen, proc_stat held.
REQ-025 proc_stat loads stat_in on the transition edge; remains 0 in RUN.
REQ-026 Faulting or halting instruction performs no register write and is not counted.
REQ-027 retired increments by 1 on each enabled write-cycle (REQ-020 condition), including instructions with no destination (nop, jXX, rmmovq).
REQ-028 retired saturates at all-ones; no wrap.
REQ-029 wb_valid=0: no write, no transition, no count, regardless of stat_in.

Reset
REQ-030 rst asserted: immediately, without clock, all 15 registers = 0, state RUN, proc_stat=0, halted=0, retired=0.
REQ-031 rst asserted mid-operation (including HALT/ERR): same as REQ-030; a write coinciding with the rst edge is lost.
REQ-032 First write possible on first rising clk after rst deasserts.

Verification
REQ-033 Reset, icode=3, rB=2, valE=64'h1234, stat_in=0, wb_valid=1, one edge -> rd_addrA=2 gives 64'h1234, retired=1.
REQ-034 icode=B, rA=4, valE=64'h100, valM=64'hABCD -> %rsp=64'hABCD after edge.
REQ-035 icode=2, cnd=0, rB=3, valE=5 -> reg3 unchanged, retired increments.
REQ-036 icode=5, stat_in=2, rA=1, valM=7 -> reg1 unchanged, proc_stat=2, halted=1; later AOK writes ignored.
REQ-037 icode=0, stat_in=1 -> proc_stat=1, halted=1, retired unchanged; assert rst between edges -> all outputs 0 asynchronously.
REQ-038 CNT_W=4, 16 AOK retirements -> retired=4'hF, holds at 4'hF.

Source files
------------

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - Y86-64 writeback stage: 15x64 register file, status FSM, retire counter.
module writeback_regfile #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  input  logic [1:0]       stat_in,
  input  logic [3:0]       rd_addrA,
  input  logic [3:0]       rd_addrB,
  output logic [63:0]      rd_dataA,
  output logic [63:0]      rd_dataB,
  output logic [1:0]       proc_stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] regs [15];
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic        wr_en;

  always_comb begin
    dst_e = REG_NONE;
    case (icode)
      4'h2:                      dst_e = cnd ? rB : REG_NONE;
      4'h3, 4'h6:                dst_e = rB;
      4'h8, 4'h9, 4'hA, 4'hB:    dst_e = REG_RSP;
      default:                   dst_e = REG_NONE;
    endcase
  end

  always_comb begin
    dst_m = REG_NONE;
    if (icode == 4'h5 || icode == 4'hB) dst_m = rA;
  end

  assign wr_en = wb_valid && (state == RUN) && (stat_in == STAT_AOK);

  // Reads see the pre-edge contents; no bypass of the write in flight.
  assign rd_dataA = (rd_addrA == REG_NONE) ? 64'h0 : regs[rd_addrA];
  assign rd_dataB = (rd_addrB == REG_NONE) ? 64'h0 : regs[rd_addrB];
  assign halted   = (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= 64'h0;
      state     <= RUN;
      proc_stat <= STAT_AOK;
      retired   <= '0;
    end else begin
      if (wr_en) begin
        // valM is written last so popq %rsp keeps the popped value.
        if (dst_e != REG_NONE) regs[dst_e] <= valE;
        if (dst_m != REG_NONE) regs[dst_m] <= valM;
        if (retired != {CNT_W{1'b1}}) retired <= retired + 1'b1;
      end
      if (wb_valid && state == RUN && stat_in != STAT_AOK) begin
        state     <= (stat_in == STAT_HLT) ? HALT : ERR;
        proc_stat <= stat_in;
      end
    end
  end

endmodule
